// File: rtl/br_lite_traffic_agent.sv
// rtl/br_lite_traffic_agent.sv - BrLite per-PE traffic agent: scheduled injection, receive ack, counters
// Schedule FIFO feeds a two-state TX FSM; an independent RX FSM acks with a fixed delay.
module br_lite_traffic_agent #(
  parameter int unsigned      X_CNT     = 4,
  parameter int unsigned      PE_IDX    = 0,
  parameter int unsigned      PAYLOAD_W = 32,
  parameter int unsigned      SVC_W     = 2,
  parameter logic [SVC_W-1:0] SVC_ALL   = SVC_W'(1),
  parameter int unsigned      ID_W      = 5,
  parameter int unsigned      DEPTH     = 16,
  parameter int unsigned      ACK_DELAY = 2,
  parameter int unsigned      DRAIN     = 300
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we_i,
  input  logic [31:0]          cfg_ts_i,
  input  logic [15:0]          cfg_tgt_i,
  input  logic [PAYLOAD_W-1:0] cfg_payload_i,
  input  logic [SVC_W-1:0]     cfg_svc_i,
  output logic                 cfg_full_o,
  output logic                 cfg_ovf_o,
  input  logic                 busy_i,
  output logic                 tx_req_o,
  input  logic                 tx_ack_i,
  output logic [15:0]          tx_src_o,
  output logic [15:0]          tx_tgt_o,
  output logic [PAYLOAD_W-1:0] tx_payload_o,
  output logic [SVC_W-1:0]     tx_svc_o,
  output logic [ID_W-1:0]      tx_id_o,
  input  logic                 rx_req_i,
  input  logic [15:0]          rx_src_i,
  input  logic [PAYLOAD_W-1:0] rx_payload_i,
  input  logic [SVC_W-1:0]     rx_svc_i,
  output logic                 rx_ack_o,
  output logic [31:0]          tick_o,
  output logic [15:0]          sent_cnt_o,
  output logic [15:0]          rx_all_cnt_o,
  output logic [15:0]          rx_tgt_cnt_o,
  output logic [31:0]          rx_sum_o,
  output logic [15:0]          rx_last_src_o,
  output logic                 done_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDLE_W = $clog2(DRAIN + 1);

  typedef enum logic {TX_IDLE, TX_REQ} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_WAIT, RX_ACK} rx_state_e;

  function automatic logic [15:0] xy_enc(input logic [15:0] idx);
    logic [31:0] v;
    v = ((32'(idx) % X_CNT) << 8) + 32'(idx) / X_CNT;
    return v[15:0];
  endfunction

  logic [31:0]          ts_mem  [DEPTH];
  logic [15:0]          tgt_mem [DEPTH];
  logic [PAYLOAD_W-1:0] pl_mem  [DEPTH];
  logic [SVC_W-1:0]     svc_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_empty, push, pop, launch;
  logic [31:0]       tick_q;
  logic              ovf_q;

  tx_state_e         tx_state_q;
  logic              tx_req_q;
  logic [15:0]       tx_tgt_q;
  logic [PAYLOAD_W-1:0] tx_payload_q;
  logic [SVC_W-1:0]  tx_svc_q;
  logic [ID_W-1:0]   tx_id_q, id_cnt_q;
  logic [15:0]       sent_q;

  rx_state_e         rx_state_q;
  logic [3:0]        dly_q;
  logic              drop_q, rx_ack_q;
  logic [15:0]       rx_all_q, rx_tgt_q, rx_last_q;
  logic [31:0]       rx_sum_q;

  logic [IDLE_W-1:0] idle_cnt_q;
  logic              idle_ok;

  assign fifo_empty = (count_q == '0);
  assign cfg_full_o = (count_q == CNT_W'(DEPTH));
  assign push       = cfg_we_i && !cfg_full_o;
  assign launch     = (tx_state_q == TX_IDLE) && !fifo_empty &&
                      (ts_mem[rd_ptr_q] <= tick_q) && !busy_i;
  assign pop        = launch;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      ts_mem[wr_ptr_q]  <= cfg_ts_i;
      tgt_mem[wr_ptr_q] <= cfg_tgt_i;
      pl_mem[wr_ptr_q]  <= cfg_payload_i;
      svc_mem[wr_ptr_q] <= cfg_svc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tick_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tick_q   <= tick_q + 32'd1;
      if (cfg_we_i && cfg_full_o) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q   <= TX_IDLE;
      tx_req_q     <= 1'b0;
      tx_tgt_q     <= '0;
      tx_payload_q <= '0;
      tx_svc_q     <= '0;
      tx_id_q      <= '0;
      id_cnt_q     <= '0;
      sent_q       <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: if (launch) begin
          tx_req_q     <= 1'b1;
          tx_tgt_q     <= xy_enc(tgt_mem[rd_ptr_q]);
          tx_payload_q <= pl_mem[rd_ptr_q];
          tx_svc_q     <= svc_mem[rd_ptr_q];
          tx_id_q      <= id_cnt_q;
          tx_state_q   <= TX_REQ;
        end
        TX_REQ: if (tx_ack_i) begin
          tx_req_q   <= 1'b0;
          id_cnt_q   <= id_cnt_q + ID_W'(1);
          if (sent_q != 16'hFFFF) sent_q <= sent_q + 16'd1;
          tx_state_q <= TX_IDLE;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      dly_q      <= '0;
      drop_q     <= 1'b0;
      rx_ack_q   <= 1'b0;
      rx_all_q   <= '0;
      rx_tgt_q   <= '0;
      rx_sum_q   <= '0;
      rx_last_q  <= '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: if (rx_req_i) begin
          dly_q      <= 4'(ACK_DELAY - 1);
          drop_q     <= 1'b0;
          rx_sum_q   <= rx_sum_q + 32'(rx_payload_i);
          rx_last_q  <= 16'((32'(rx_src_i) >> 8) + (32'(rx_src_i) & 32'hFF) * X_CNT);
          if (rx_svc_i == SVC_ALL) begin
            if (rx_all_q != 16'hFFFF) rx_all_q <= rx_all_q + 16'd1;
          end else begin
            if (rx_tgt_q != 16'hFFFF) rx_tgt_q <= rx_tgt_q + 16'd1;
          end
          rx_state_q <= RX_WAIT;
        end
        RX_WAIT: begin
          // Remember an early release so the ack becomes a single-cycle pulse.
          if (!rx_req_i) drop_q <= 1'b1;
          if (dly_q == 4'd0) begin
            rx_ack_q   <= 1'b1;
            rx_state_q <= RX_ACK;
          end else begin
            dly_q <= dly_q - 4'd1;
          end
        end
        RX_ACK: if (!rx_req_i || drop_q) begin
          rx_ack_q   <= 1'b0;
          rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign idle_ok = fifo_empty && (tx_state_q == TX_IDLE) && (rx_state_q == RX_IDLE) &&
                   (sent_q != 16'd0) && !cfg_we_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              idle_cnt_q <= '0;
    else if (!idle_ok)                       idle_cnt_q <= '0;
    else if (idle_cnt_q != IDLE_W'(DRAIN))   idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
  end

  assign done_o        = idle_ok && (idle_cnt_q == IDLE_W'(DRAIN));
  assign cfg_ovf_o     = ovf_q;
  assign tx_src_o      = xy_enc(16'(PE_IDX));
  assign tx_req_o      = tx_req_q;
  assign tx_tgt_o      = tx_tgt_q;
  assign tx_payload_o  = tx_payload_q;
  assign tx_svc_o      = tx_svc_q;
  assign tx_id_o       = tx_id_q;
  assign rx_ack_o      = rx_ack_q;
  assign tick_o        = tick_q;
  assign sent_cnt_o    = sent_q;
  assign rx_all_cnt_o  = rx_all_q;
  assign rx_tgt_cnt_o  = rx_tgt_q;
  assign rx_sum_o      = rx_sum_q;
  assign rx_last_src_o = rx_last_q;

endmodule

// File: tb/tb_br_lite_traffic_agent.sv
// tb/tb_br_lite_traffic_agent.sv - scoreboard bench for br_lite_traffic_agent
module tb_br_lite_traffic_agent;

  localparam int ACK_DELAY = 2;
  localparam int DRAIN     = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [31:0] cfg_ts_i = '0;
  logic [15:0] cfg_tgt_i = '0;
  logic [31:0] cfg_payload_i = '0;
  logic [1:0]  cfg_svc_i = '0;
  logic        cfg_full_o, cfg_ovf_o;
  logic        busy_i = 1'b0;
  logic        tx_req_o;
  logic        tx_ack_i = 1'b0;
  logic [15:0] tx_src_o, tx_tgt_o;
  logic [31:0] tx_payload_o;
  logic [1:0]  tx_svc_o;
  logic [4:0]  tx_id_o;
  logic        rx_req_i = 1'b0;
  logic [15:0] rx_src_i = '0;
  logic [31:0] rx_payload_i = '0;
  logic [1:0]  rx_svc_i = '0;
  logic        rx_ack_o;
  logic [31:0] tick_o;
  logic [15:0] sent_cnt_o, rx_all_cnt_o, rx_tgt_cnt_o, rx_last_src_o;
  logic [31:0] rx_sum_o;
  logic        done_o;

  br_lite_traffic_agent #(
    .X_CNT(4), .PE_IDX(0), .PAYLOAD_W(32), .SVC_W(2), .SVC_ALL(2'd1), .ID_W(5),
    .DEPTH(16), .ACK_DELAY(ACK_DELAY), .DRAIN(DRAIN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we_i(cfg_we_i), .cfg_ts_i(cfg_ts_i), .cfg_tgt_i(cfg_tgt_i),
    .cfg_payload_i(cfg_payload_i), .cfg_svc_i(cfg_svc_i),
    .cfg_full_o(cfg_full_o), .cfg_ovf_o(cfg_ovf_o), .busy_i(busy_i),
    .tx_req_o(tx_req_o), .tx_ack_i(tx_ack_i), .tx_src_o(tx_src_o), .tx_tgt_o(tx_tgt_o),
    .tx_payload_o(tx_payload_o), .tx_svc_o(tx_svc_o), .tx_id_o(tx_id_o),
    .rx_req_i(rx_req_i), .rx_src_i(rx_src_i), .rx_payload_i(rx_payload_i),
    .rx_svc_i(rx_svc_i), .rx_ack_o(rx_ack_o), .tick_o(tick_o),
    .sent_cnt_o(sent_cnt_o), .rx_all_cnt_o(rx_all_cnt_o), .rx_tgt_cnt_o(rx_tgt_cnt_o),
    .rx_sum_o(rx_sum_o), .rx_last_src_o(rx_last_src_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  id;
    logic [15:0] tgt;
    logic [31:0] pl;
    logic [1:0]  svc;
    int          exp_tick;
  } flit_t;

  flit_t       sb[$];
  flit_t       mon_f;
  int          n_chk = 0;
  int          n_err = 0;
  logic [4:0]  exp_id = '0;
  bit          ack_en = 1'b1;
  bit          req_seen = 1'b0;
  logic        prev_req = 1'b0;
  int          ack_cnt = 0;
  logic [54:0] held = '0;
  logic [31:0] m_sum = '0;
  logic [15:0] m_all = '0, m_tgt = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [15:0] t);
    logic [31:0] v;
    v = ((32'(t) % 32'd4) << 8) + 32'(t) / 32'd4;
    return v[15:0];
  endfunction

  // Router model: acks two cycles after each request rises, checks flits against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
      ack_cnt  = 0;
      tx_ack_i = 1'b0;
    end else begin
      if (tx_req_o && !prev_req) begin
        req_seen = 1'b1;
        held     = {tx_id_o, tx_tgt_o, tx_payload_o, tx_svc_o};
        ack_cnt  = 0;
        if (sb.size() == 0) begin
          check("tx_unexpected", 64'(1), 64'(0));
        end else begin
          mon_f = sb.pop_front();
          check("tx_flit", 64'(held), 64'({mon_f.id, mon_f.tgt, mon_f.pl, mon_f.svc}));
          if (mon_f.exp_tick >= 0) check("tx_tick", 64'(tick_o), 64'(mon_f.exp_tick));
        end
      end else if (tx_req_o) begin
        check("tx_hold", 64'({tx_id_o, tx_tgt_o, tx_payload_o, tx_svc_o}), 64'(held));
      end
      if (tx_req_o) ack_cnt++;
      tx_ack_i = tx_req_o && ack_en && (ack_cnt >= 2);
      prev_req = tx_req_o;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_a"}, 64'({tx_req_o, rx_ack_o, cfg_full_o, cfg_ovf_o, done_o, tx_svc_o, tx_id_o, tx_tgt_o}), 64'(0));
    check({tag, "_b"}, 64'({tick_o, tx_payload_o}), 64'(0));
    check({tag, "_c"}, 64'({sent_cnt_o, rx_all_cnt_o, rx_tgt_cnt_o, rx_last_src_o}), 64'(0));
    check({tag, "_d"}, 64'(rx_sum_o), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    exp_id = '0;
    m_sum = '0; m_all = '0; m_tgt = '0;
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
  endtask

  task automatic cfg_push(input logic [31:0] ts, input logic [15:0] tgt, input logic [31:0] pl,
                          input logic [1:0] svc, input bit drop, input int et);
    flit_t f;
    @(negedge clk);
    cfg_ts_i = ts; cfg_tgt_i = tgt; cfg_payload_i = pl; cfg_svc_i = svc;
    cfg_we_i = 1'b1;
    if (!drop) begin
      f.id = exp_id; f.tgt = enc(tgt); f.pl = pl; f.svc = svc; f.exp_tick = et;
      sb.push_back(f);
      exp_id = exp_id + 5'd1;
    end
    @(negedge clk);
    cfg_we_i = 1'b0;
  endtask

  task automatic wait_sent(input logic [15:0] n, input int budget);
    for (int i = 0; i < budget && sent_cnt_o != n; i++) @(negedge clk);
    check("sent_cnt", 64'(sent_cnt_o), 64'(n));
  endtask

  task automatic rx_pulse(input logic [1:0] svc, input logic [31:0] pl, input logic [15:0] src, input bit hold);
    int lat;
    @(negedge clk);
    rx_svc_i = svc; rx_payload_i = pl; rx_src_i = src; rx_req_i = 1'b1;
    m_sum = m_sum + pl;
    if (svc == 2'd1) m_all = m_all + 16'd1; else m_tgt = m_tgt + 16'd1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) rx_req_i = 1'b0;
    end while (!rx_ack_o && lat < 20);
    check("rx_latency", 64'(lat), 64'(ACK_DELAY + 1));
    rx_req_i = 1'b0;
    @(negedge clk);
    check("rx_ack_release", 64'(rx_ack_o), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("tx_src", 64'(tx_src_o), 64'(0));

    // Timed injection: ts 10/20/20, expected rise ticks 11, 21, 24.
    cfg_push(32'd10, 16'd5, 32'hA, 2'd1, 1'b0, 11);
    cfg_push(32'd20, 16'd5, 32'hB, 2'd1, 1'b0, 21);
    cfg_push(32'd20, 16'd5, 32'hC, 2'd1, 1'b0, 24);
    wait_sent(16'd3, 200);

    // Busy hold-off until tick 51.
    busy_i = 1'b1;
    do_reset();
    cfg_push(32'd10, 16'd3, 32'h55, 2'd0, 1'b0, 52);
    for (int i = 0; i < 100 && tick_o != 32'd51; i++) @(negedge clk);
    busy_i = 1'b0;
    wait_sent(16'd1, 50);

    // Fill to full, overflow on the 17th write.
    busy_i = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) cfg_push(32'd0, 16'(i), 32'(i) + 32'h100, 2'(i), 1'b0, -1);
    check("full_16", 64'(cfg_full_o), 64'(1));
    check("ovf_16", 64'(cfg_ovf_o), 64'(0));
    cfg_push(32'd0, 16'd9, 32'h99, 2'd0, 1'b1, -1);
    check("ovf_17", 64'(cfg_ovf_o), 64'(1));
    busy_i = 1'b0;
    wait_sent(16'd16, 400);
    repeat (10) @(negedge clk);
    check("no_extra_tx", 64'(sent_cnt_o), 64'(16));
    check("ovf_sticky", 64'(cfg_ovf_o), 64'(1));

    // 34 packets: ID wraps 31 -> 0 on the 33rd.
    do_reset();
    for (int i = 0; i < 34; i++) begin
      for (int w = 0; w < 100 && cfg_full_o; w++) @(negedge clk);
      cfg_push(32'd0, 16'(i % 16), 32'h1000 + 32'(i), 2'(i % 4), 1'b0, -1);
    end
    wait_sent(16'd34, 1000);

    // Receive side.
    rx_pulse(2'd1, 32'hFFFF_FFFF, 16'h0000, 1'b1);
    rx_pulse(2'd2, 32'd2, 16'h0201, 1'b1);
    check("rx_all", 64'(rx_all_cnt_o), 64'(m_all));
    check("rx_tgt", 64'(rx_tgt_cnt_o), 64'(m_tgt));
    check("rx_sum", 64'(rx_sum_o), 64'(m_sum));
    check("rx_last", 64'(rx_last_src_o), 64'(6));
    rx_pulse(2'd0, 32'd5, 16'h0102, 1'b0);
    check("rx_tgt_drop", 64'(rx_tgt_cnt_o), 64'(m_tgt));
    check("rx_sum_drop", 64'(rx_sum_o), 64'(m_sum));
    check("rx_last_drop", 64'(rx_last_src_o), 64'(9));

    // done_o after the drain window; drops on a new write.
    for (int i = 0; i < DRAIN + 50 && !done_o; i++) @(negedge clk);
    check("done_set", 64'(done_o), 64'(1));
    @(negedge clk);
    begin
      flit_t f;
      cfg_ts_i = 32'd0; cfg_tgt_i = 16'd7; cfg_payload_i = 32'h77; cfg_svc_i = 2'd3;
      cfg_we_i = 1'b1;
      f.id = exp_id; f.tgt = enc(16'd7); f.pl = 32'h77; f.svc = 2'd3; f.exp_tick = -1;
      sb.push_back(f);
      exp_id = exp_id + 5'd1;
      #1;
      check("done_drop", 64'(done_o), 64'(0));
    end
    @(negedge clk);
    cfg_we_i = 1'b0;
    wait_sent(16'd35, 100);

    // Reset in the middle of TX_REQ and RX_ACK.
    ack_en = 1'b0;
    cfg_push(32'd0, 16'd1, 32'hDEAD, 2'd1, 1'b0, -1);
    @(negedge clk);
    rx_svc_i = 2'd1; rx_payload_i = 32'h3; rx_src_i = 16'h0101; rx_req_i = 1'b1;
    for (int i = 0; i < 50 && !(tx_req_o && rx_ack_o); i++) @(negedge clk);
    check("both_active", 64'({tx_req_o, rx_ack_o}), 64'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    sb.delete();
    exp_id = '0;
    rx_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_seen = 1'b0;
    ack_en = 1'b1;
    repeat (20) @(negedge clk);
    check("no_req_after_rst", 64'(req_seen), 64'(0));
    check("sent_after_rst", 64'(sent_cnt_o), 64'(0));
    cfg_push(32'd0, 16'd2, 32'hBEEF, 2'd0, 1'b0, -1);
    wait_sent(16'd1, 50);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
